// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a running mod-2^32 checksum output of the words written.
`default_nettype none

module imem_loader #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   input  logic                  byte_last,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_written,
   output logic                  err_partial,
   output logic                  err_overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [1:0]            byte_cnt_q;
   logic [DATA_WIDTH-1:0] pack_q;
   logic                  last_q;
   logic                  byte_ready_q;
   logic                  imem_we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  cpu_hold_q;
   logic                  busy_q;
   logic                  done_q;
   logic [ADDR_WIDTH:0]   words_q;
   logic                  err_partial_q;
   logic                  err_overflow_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]           checksum_q;
`endif

   logic [DATA_WIDTH-1:0] word_d;
   logic                  xfer_d;
   logic                  addr_full_d;

   // Merge the incoming byte into its big-endian slot of the partially packed word.
   always_comb begin
      word_d = pack_q;
      case (byte_cnt_q)
         2'd0:    word_d[31:24] = byte_data;
         2'd1:    word_d[23:16] = byte_data;
         2'd2:    word_d[15:8]  = byte_data;
         default: word_d[7:0]   = byte_data;
      endcase
   end

   assign xfer_d      = byte_valid && byte_ready_q;
   assign addr_full_d = &addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         byte_cnt_q     <= 2'd0;
         pack_q         <= '0;
         last_q         <= 1'b0;
         byte_ready_q   <= 1'b0;
         imem_we_q      <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         cpu_hold_q     <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         words_q        <= '0;
         err_partial_q  <= 1'b0;
         err_overflow_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         checksum_q     <= '0;
`endif
      end else begin
         imem_we_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q        <= S_RECV;
                  byte_cnt_q     <= 2'd0;
                  pack_q         <= '0;
                  last_q         <= 1'b0;
                  byte_ready_q   <= 1'b1;
                  addr_q         <= '0;
                  cpu_hold_q     <= 1'b1;
                  busy_q         <= 1'b1;
                  done_q         <= 1'b0;
                  words_q        <= '0;
                  err_partial_q  <= 1'b0;
                  err_overflow_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  checksum_q     <= '0;
`endif
               end
            end
            S_RECV: begin
               if (xfer_d) begin
                  if (byte_last || (byte_cnt_q == 2'd3)) begin
                     state_q      <= S_WRITE;
                     byte_ready_q <= 1'b0;
                     imem_we_q    <= 1'b1;
                     wdata_q      <= word_d;
                     last_q       <= byte_last;
                     if (byte_last && (byte_cnt_q != 2'd3)) begin
                        err_partial_q <= 1'b1;
                     end
                  end else begin
                     pack_q     <= word_d;
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                  end
               end
            end
            S_WRITE: begin
               words_q    <= words_q + 1'b1;
               byte_cnt_q <= 2'd0;
               pack_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               checksum_q <= checksum_q + wdata_q;
`endif
               // Address saturates at the top of memory instead of wrapping.
               if (!addr_full_d) begin
                  addr_q <= addr_q + 1'b1;
               end
               if (last_q || addr_full_d) begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  cpu_hold_q <= 1'b0;
                  busy_q     <= 1'b0;
                  if (!last_q) begin
                     err_overflow_q <= 1'b1;
                  end
               end else begin
                  state_q      <= S_RECV;
                  byte_ready_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign byte_ready    = byte_ready_q;
   assign imem_we       = imem_we_q;
   assign imem_addr     = addr_q;
   assign imem_wdata    = wdata_q;
   assign cpu_hold      = cpu_hold_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign words_written = words_q;
   assign err_partial   = err_partial_q;
   assign err_overflow  = err_overflow_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign checksum      = checksum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// Scoreboard testbench for imem_loader: expected writes are queued at stimulus time, a monitor pops them on imem_we.
`default_nettype none

module tb_imem_loader;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_last = 1'b0;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold;
   logic          busy;
   logic          done;
   logic [AW:0]   words_written;
   logic          err_partial;
   logic          err_overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_last     (byte_last),
      .byte_ready    (byte_ready),
      .imem_we       (imem_we),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .cpu_hold      (cpu_hold),
      .busy          (busy),
      .done          (done),
      .words_written (words_written),
      .err_partial   (err_partial),
      .err_overflow  (err_overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .checksum      (checksum)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   logic prev_we = 1'b0;

   // Monitor: every write strobe must match the oldest queued expectation and last one cycle.
   always @(negedge clk) begin
      if (imem_we) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
               fails++;
               $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                        imem_addr, imem_wdata, mon_e.addr, mon_e.data);
            end
         end
         if (prev_we) begin
            tests++;
            fails++;
            $display("FAIL we_width: got imem_we high 2+ cycles, required 1");
         end
      end
      prev_we = imem_we;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic l);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      byte_last  = l;
      @(negedge clk);
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         tests++;
         fails++;
         $display("FAIL byte_accept_timeout: got byte_ready=0 for 50 cycles, required 1");
      end
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic send_gappy(input logic [7:0] b, input logic l);
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_byte(b, l);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got done=0 after 200 cycles, required 1");
      end
   endtask

   function automatic logic [31:0] status();
      return {16'h0, byte_ready, imem_we, cpu_hold, busy, done, err_partial, err_overflow,
              words_written, imem_addr};
   endfunction

   logic seen_ready;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_state", status(), 32'h0);
      check("reset_wdata", imem_wdata, 32'h0);

      // Two full words
      push_wr(4'd0, 32'h8F100000);
      push_wr(4'd1, 32'h03213023);
      pulse_start();
      check("hold_busy_on_start", {30'h0, cpu_hold, busy}, 32'h3);
      send_byte(8'h8F, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h21, 1'b0);
      send_byte(8'h30, 1'b0);
      send_byte(8'h23, 1'b1);
      wait_done();
      check("full_words_written", {27'h0, words_written}, 32'd2);
      check("full_errors", {30'h0, err_partial, err_overflow}, 32'h0);
      check("full_hold_busy_at_done", {30'h0, cpu_hold, busy}, 32'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("full_checksum", checksum, 32'h92313023);
`endif

      // Partial word
      push_wr(4'd0, 32'hAABB0000);
      pulse_start();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b1);
      wait_done();
      check("partial_err_partial", {31'h0, err_partial}, 32'h1);
      check("partial_err_overflow", {31'h0, err_overflow}, 32'h0);
      check("partial_words_written", {27'h0, words_written}, 32'd1);

      // Overflow: 64 bytes, no last
      for (int j = 0; j < 16; j++) begin
         push_wr(j[AW-1:0], {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)});
      end
      pulse_start();
      for (int i = 0; i < 64; i++) begin
         send_byte(8'(i), 1'b0);
      end
      wait_done();
      check("ovf_err_overflow", {31'h0, err_overflow}, 32'h1);
      check("ovf_err_partial", {31'h0, err_partial}, 32'h0);
      check("ovf_words_written", {27'h0, words_written}, 32'd16);
      byte_valid = 1'b1;
      byte_data  = 8'hEE;
      seen_ready = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen_ready = seen_ready | byte_ready;
      end
      byte_valid = 1'b0;
      check("ovf_ready_stays_low", {31'h0, seen_ready}, 32'h0);

      // Back-pressure and gaps
      push_wr(4'd0, 32'h01020304);
      pulse_start();
      send_gappy(8'h01, 1'b0);
      send_gappy(8'h02, 1'b0);
      send_gappy(8'h03, 1'b0);
      send_gappy(8'h04, 1'b1);
      wait_done();
      check("gap_words_written", {27'h0, words_written}, 32'd1);
      check("gap_errors", {30'h0, err_partial, err_overflow}, 32'h0);

      // Reset mid-word
      pulse_start();
      send_byte(8'hCA, 1'b0);
      send_byte(8'hFE, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midreset_state", status(), 32'h0);
      check("midreset_wdata", imem_wdata, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      push_wr(4'd0, 32'h5A000000);
      pulse_start();
      send_byte(8'h5A, 1'b1);
      wait_done();
      check("postreset_err_partial", {31'h0, err_partial}, 32'h1);
      check("postreset_words_written", {27'h0, words_written}, 32'd1);

      // Restart from DONE with error flag set
      push_wr(4'd0, 32'h11223344);
      pulse_start();
      check("restart_done_cleared", {31'h0, done}, 32'h0);
      check("restart_errors_cleared", {30'h0, err_partial, err_overflow}, 32'h0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      wait_done();
      check("restart_words_written", {27'h0, words_written}, 32'd1);
      check("restart_errors", {30'h0, err_partial, err_overflow}, 32'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("restart_checksum", checksum, 32'h11223344);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got simulation still running, required completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
